mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single DRAM-side Sysbus port between two cache requesters: requester 0 is the I-cache and requester 1 is the D-cache.
- Grants one requester at a time and holds the grant for the whole transaction:
  - read: address beat plus BEATS response beats;
  - write: address beat plus BEATS data beats.
- Arbitration between simultaneous requesters is round-robin.
- Sits between the two caches and the memory bus; transaction semantics are unchanged for both sides.

Parameters:
BUS_DATA_WIDTH, 64, width of req/resp data
BUS_TAG_WIDTH, 13, width of tags; bit [BUS_TAG_WIDTH-1] == `SYSBUS_WRITE marks a write
BEATS, 8, data beats per cache line (64B line / 8B bus)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
r0_reqcyc  input  1  requester 0 request valid
r0_reqack  output  1  request/data beat accepted, to requester 0
r0_req  input  BUS_DATA_WIDTH  address or write-data beat from requester 0
r0_reqtag  input  BUS_TAG_WIDTH  request tag from requester 0
r0_respcyc  output  1  response beat valid, to requester 0
r0_respack  input  1  requester 0 accepts response beat
r0_resp  output  BUS_DATA_WIDTH  response data, to requester 0
r0_resptag  output  BUS_TAG_WIDTH  response tag, to requester 0
r1_*  (same 8 signals as r0_*, for requester 1)
m_bus_reqcyc  output  1  memory request valid
m_bus_reqack  input  1  memory accepts beat
m_bus_req  output  BUS_DATA_WIDTH  address/data to memory
m_bus_reqtag  output  BUS_TAG_WIDTH  tag to memory
m_bus_respcyc  input  1  memory response valid
m_bus_respack  output  1  response accepted
m_bus_resp  input  BUS_DATA_WIDTH  response data
m_bus_resptag  input  BUS_TAG_WIDTH  response tag

Behaviour:
- Reset (synchronous, active-high): state=IDLE, gnt=0, last=1 (requester 0 wins the first tie), beat=0. All outputs are 0 during reset and in the cycle after.
- States: IDLE, ADDR, WDATA, RESP. Registers: gnt (1b), last (1b), is_wr (1b), beat (log2(BEATS)+1 bits).
- IDLE:
  - All outputs 0.
  - If exactly one rN_reqcyc=1: gnt<=N.
  - If both are 1: gnt<=~last.
  - When any request is present: is_wr<=(tag of the winner)[BUS_TAG_WIDTH-1]==`SYSBUS_WRITE; go to ADDR.
  - Grant therefore takes effect one cycle after the request is first seen; no beat is forwarded in IDLE.
- Muxing in ADDR and WDATA (combinational):
  - m_bus_reqcyc=r[gnt]_reqcyc; m_bus_req=r[gnt]_req; m_bus_reqtag=r[gnt]_reqtag.
  - r[gnt]_reqack=m_bus_reqack. Non-granted reqack=0.
- ADDR: on m_bus_reqack && r[gnt]_reqcyc:
  - if is_wr, beat<=0 and go to WDATA;
  - else beat<=0 and go to RESP.
- WDATA:
  - Each cycle with reqcyc&&reqack, beat increments.
  - When the beat with beat==BEATS-1 is accepted: last<=gnt, go to IDLE.
- RESP (combinational forwarding):
  - r[gnt]_respcyc=m_bus_respcyc; r[gnt]_resp=m_bus_resp; r[gnt]_resptag=m_bus_resptag.
  - m_bus_respack=r[gnt]_respack & m_bus_respcyc.
  - Each accepted beat increments beat. After the accepted beat with beat==BEATS-1: last<=gnt, go to IDLE.
- Stray responses: m_bus_respcyc outside RESP is never acked (m_bus_respack=0) and never forwarded.
- Non-granted requester: reqack=0, respcyc=0, resp/resptag=0. Its reqcyc may stay high indefinitely and is served at the next IDLE.
- Deasserted reqcyc: if the granted requester drops reqcyc in ADDR/WDATA, m_bus_reqcyc drops and the state holds. No abort; the grant stays.
- Fairness: back-to-back requests from both sides alternate 0,1,0,1. A lone requester may be granted consecutively.
- Reset mid-transaction aborts immediately: state→IDLE, beat count lost, last=1.
- No combinational path from r[~gnt] inputs to any output.

Test Plan:
- Single read, r0 only: r0_reqcyc=1, addr 0x1000, tag read; mem acks after 2 cycles, returns 8 beats 0xA0..0xA7 → m_bus_req=0x1000; r0 receives 8 beats in order with matching tags; r1 outputs stay 0; back in IDLE after the 8th respack.
- Simultaneous reads after reset: r0 and r1 request the same cycle → r0 served first (last=1); r1 granted in the first IDLE after r0's 8th beat; a third simultaneous request pair grants r0 again.
- Write, r1 only: tag with `SYSBUS_WRITE, addr 0x2040, then 8 data beats 0xD0..0xD7 with reqack toggling every other cycle → memory sees address then exactly 8 data beats in order; m_bus_respack stays 0 throughout; return to IDLE after the 8th ack.
- Response backpressure: during r0 read, r0_respack=0 for 3 cycles on beat 4 → m_bus_respack=0 for those cycles; beat not counted; all 8 beats delivered exactly once.
- Stray response: m_bus_respcyc=1 while IDLE → m_bus_respack=0, r0/r1 respcyc=0, state stays IDLE.
- Reset on beat 5 of an r1 read → the following cycle all outputs are 0; a new r0 request is granted normally with beat count restarting at 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one DRAM-side Sysbus port between two cache requesters
//   (requester 0 = I-cache, requester 1 = D-cache). One requester is granted
//   at a time, and the grant is held for the whole transaction:
//     read : address beat, then BEATS response beats
//     write: address beat, then BEATS write-data beats
//   Simultaneous requests are resolved round-robin.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   rN_reqcyc / rN_reqack         request beat handshake, requester N
//   rN_req / rN_reqtag            address or write data, and tag, from requester N
//   rN_respcyc / rN_respack       response beat handshake, requester N
//   rN_resp / rN_resptag          response data and tag, to requester N
//   m_bus_reqcyc / m_bus_reqack   request beat handshake, memory side
//   m_bus_req / m_bus_reqtag      address or write data, and tag, to memory
//   m_bus_respcyc / m_bus_respack response beat handshake, memory side
//   m_bus_resp / m_bus_resptag    response data and tag from memory
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    // requester 0 (I-cache)
    input  logic                      r0_reqcyc,
    output logic                      r0_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] r0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  r0_reqtag,
    output logic                      r0_respcyc,
    input  logic                      r0_respack,
    output logic [BUS_DATA_WIDTH-1:0] r0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  r0_resptag,
    // requester 1 (D-cache)
    input  logic                      r1_reqcyc,
    output logic                      r1_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] r1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  r1_reqtag,
    output logic                      r1_respcyc,
    input  logic                      r1_respack,
    output logic [BUS_DATA_WIDTH-1:0] r1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  r1_resptag,
    // memory side
    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

    // Tag MSB value that marks a write transaction.
    localparam logic SYSBUS_WRITE = 1'b1;
    localparam int   BW           = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_e;

    state_e          state_q, state_d;
    logic            gnt_q,   gnt_d;
    logic            last_q,  last_d;
    logic            is_wr_q, is_wr_d;
    logic [BW-1:0]   beat_q,  beat_d;

    // Signals of the currently granted requester; selected only by gnt_q so
    // the non-granted side has no combinational path to any output.
    logic                      g_reqcyc;
    logic                      g_respack;
    logic [BUS_DATA_WIDTH-1:0] g_req;
    logic [BUS_TAG_WIDTH-1:0]  g_reqtag;
    logic                      last_beat;

    // IDLE arbitration
    logic                      win;
    logic                      win_tag_msb;

    assign g_reqcyc  = gnt_q ? r1_reqcyc  : r0_reqcyc;
    assign g_respack = gnt_q ? r1_respack : r0_respack;
    assign g_req     = gnt_q ? r1_req     : r0_req;
    assign g_reqtag  = gnt_q ? r1_reqtag  : r0_reqtag;
    assign last_beat = (beat_q == BW'(BEATS - 1));

    // On a tie the requester not served last wins; otherwise whoever asks.
    assign win         = (r0_reqcyc && r1_reqcyc) ? ~last_q : r1_reqcyc;
    assign win_tag_msb = win ? r1_reqtag[BUS_TAG_WIDTH-1] : r0_reqtag[BUS_TAG_WIDTH-1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            is_wr_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            is_wr_q <= is_wr_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        is_wr_d = is_wr_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (r0_reqcyc || r1_reqcyc) begin
                    gnt_d   = win;
                    is_wr_d = (win_tag_msb == SYSBUS_WRITE);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (g_reqcyc && m_bus_reqack) begin
                    beat_d  = '0;
                    state_d = is_wr_q ? WDATA : RESP;
                end
            end
            WDATA: begin
                if (g_reqcyc && m_bus_reqack) begin
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        last_d  = gnt_q;
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (m_bus_respcyc && g_respack) begin
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        last_d  = gnt_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is asserted so the
    // buses are quiet even before the reset edge has been taken.
    always_comb begin
        r0_reqack     = 1'b0;
        r0_respcyc    = 1'b0;
        r0_resp       = '0;
        r0_resptag    = '0;
        r1_reqack     = 1'b0;
        r1_respcyc    = 1'b0;
        r1_resp       = '0;
        r1_resptag    = '0;
        m_bus_reqcyc  = 1'b0;
        m_bus_req     = '0;
        m_bus_reqtag  = '0;
        m_bus_respack = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ADDR, WDATA: begin
                    m_bus_reqcyc = g_reqcyc;
                    m_bus_req    = g_req;
                    m_bus_reqtag = g_reqtag;
                    if (gnt_q) r1_reqack = m_bus_reqack;
                    else       r0_reqack = m_bus_reqack;
                end
                RESP: begin
                    m_bus_respack = g_respack & m_bus_respcyc;
                    if (gnt_q) begin
                        r1_respcyc = m_bus_respcyc;
                        r1_resp    = m_bus_resp;
                        r1_resptag = m_bus_resptag;
                    end else begin
                        r0_respcyc = m_bus_respcyc;
                        r0_resp    = m_bus_resp;
                        r0_resptag = m_bus_resptag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
